sprite_layer_renderer: RTL and testbench
========================================

# sprite_layer_renderer

Parametrised pixel renderer for the VGA path; replaces the single-sprite renderer. It composites up to N_SPRITES animated, mirrorable sprites over a flat background colour. Each sprite has per-frame animation and a colour-key transparency, with strict index priority. It sits between the VGA timing generator (X, Y, display_on) and the DAC output register. It drives external sprite ROMs through a latency-aligned pipeline.

## Interface
- N_SPRITES, 2, number of sprite layers; index 0 has the highest priority.
- SPRITE_W, 37, sprite width in pixels.
- SPRITE_H, 42, sprite height in pixels.
- FRAMES, 4, number of animation frames per sprite ROM.
- ANIM_DIV, 6, number of video frames per animation step; must be ≥1.
- ROM_LATENCY, 1, sprite ROM read latency in cycles; must be ≥1.
- KEY_COLOUR, 24'hFF0096, transparent colour key.
- BG_COLOUR, 24'h2222EE, background colour during play.
- VGA_clk  in  1  pixel clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- display_on  in  1  active-video flag, aligned with X and Y.
- frame_start  in  1  one-cycle pulse once per video frame, during blanking.
- game_state  in  4  1 = play, 2 = pause; every other value means black output.
- X, Y  in  16 each  current pixel coordinate.
- sprite_x, sprite_y  in  16·N_SPRITES each  top-left position of sprite i, in slice [16i+15:16i].
- sprite_dir  in  N_SPRITES  1 = horizontally mirrored.
- sprite_en  in  N_SPRITES  layer enable.
- sprite_anim  in  N_SPRITES  1 = animation advances.
- rom_row  out  8·N_SPRITES  ROM row address.
- rom_col  out  8·N_SPRITES  ROM column address.
- rom_frame  out  $clog2(FRAMES)·N_SPRITES  ROM frame select.
- rom_data  in  24·N_SPRITES  ROM pixel data, valid ROM_LATENCY cycles after the address.
- RGB  out  24  registered output colour.

## Operation
- Hit test per sprite, stage 0, combinational:
  - dx = X − sprite_x[i] and dy = Y − sprite_y[i], computed as 16-bit unsigned with wrap-around.
  - hit_i = sprite_en[i] && dx < SPRITE_W && dy < SPRITE_H.
  - Negative offsets wrap to large values and therefore miss.
- Address generation:
  - rom_row = dy[7:0].
  - rom_col = sprite_dir[i] ? SPRITE_W−1−dx : dx. This gives exact mirroring with no off-by-one.
  - rom_frame = frame_idx[i].
  - All three are registered, so the ROM sees them 1 cycle after X and Y.
- Alignment: hit_i, display_on and game_state are delayed by ROM_LATENCY+1 cycles in shift registers so that they line up with rom_data.
- Composite, final stage:
  - Select the lowest i whose delayed hit_i is set and whose rom_data[i] ≠ KEY_COLOUR.
  - If no sprite qualifies, use BG_COLOUR.
- Output selection, using the delayed values:
  - display_on = 0 → RGB = 0.
  - game_state = 1 → composite.
  - game_state = 2 → composite, modified as described under Configuration.
  - Any other game_state → RGB = 0.
- Animation, per sprite, registers tick_i and frame_idx_i:
  - Update only on frame_start, and only while game_state = 1.
  - If sprite_anim[i] = 0: tick_i ← 0 and frame_idx_i ← 0.
  - Otherwise, if tick_i = ANIM_DIV−1: tick_i ← 0 and frame_idx_i ← (frame_idx_i+1) mod FRAMES.
  - Otherwise: tick_i ← tick_i+1.
  - In pause (game_state = 2), both registers hold.
  - frame_idx never changes mid-frame, so there is no tearing.

## Timing
- Latency from X/Y to RGB is ROM_LATENCY+2 cycles. Breakdown: 1 cycle address register, ROM_LATENCY cycles ROM read, 1 cycle RGB register. The timing generator compensates for this latency.
- Reset values: RGB = 0, rom_row = rom_col = rom_frame = 0, all tick and frame_idx registers = 0, all delay pipelines = 0.
- Reset asserted mid-line: outputs drop to 0 immediately. After release, RGB is 0 for ROM_LATENCY+2 cycles until the pipeline refills.
- Throughput: one pixel per clock, with no stalls.
- game_state change: takes effect on RGB after ROM_LATENCY+2 cycles, in order with the pixels.
- frame_start coinciding with a sprite_anim deassertion: the reset-to-0 branch wins.
- Overlapping sprites: the lower index wins. If the lower-index sprite is key-coloured at that pixel, the next index shows through.

## Configuration
- RENDER_PAUSE_DIM_EN defined: in game_state 2, each channel of the composite colour is shifted right by 1 (dimmed; e.g. 24'h2222EE → 24'h111177).
- RENDER_PAUSE_DIM_EN undefined: game_state 2 renders identically to game_state 1. Animation still freezes.

## Test plan
- Background: reset, game_state = 1, no sprites enabled, display_on = 1 → RGB = 24'h2222EE from cycle ROM_LATENCY+2 onward; RGB = 0 while display_on = 0.
- Mirroring: sprite 0 at (100,50), dir = 0 → at X = 100, Y = 50, rom_col = 0; dir = 1 at the same pixel → rom_col = 36; X = 99 → miss; X = 137 → miss.
- Transparency and priority: sprites 0 and 1 overlap; rom_data[0] = KEY_COLOUR and rom_data[1] = 24'h00FF00 → RGB = 24'h00FF00. With rom_data[0] = 24'hFF0000 → RGB = 24'hFF0000.
- Animation: sprite_anim[0] = 1, ANIM_DIV = 6, FRAMES = 4, 30 frame_start pulses → rom_frame sequence 0,1,2,3,0 with steps every 6 pulses. Switch to game_state = 2 → frame holds through 10 pulses. Clear sprite_anim → frame returns to 0 on the next pulse.
- Pause dim: with the macro defined, game_state = 2 over background → RGB = 24'h111177. Without the macro → 24'h2222EE. game_state = 4 → RGB = 0.
- Reset mid-frame: assert rst while a sprite pixel is output → RGB = 0 and rom_frame = 0 immediately. After release, the first valid pixel appears exactly ROM_LATENCY+2 cycles later.

Source files
------------

// File: rtl/sprite_layer_renderer.sv
// sprite_layer_renderer
//
// Composites up to N_SPRITES animated, mirrorable sprites over a flat
// background colour for the VGA pixel path. Sprite index 0 has the highest
// priority, and a pixel equal to KEY_COLOUR is transparent. The external
// sprite ROMs are driven through a pipeline aligned to their latency. The
// latency from X/Y to RGB is ROM_LATENCY+2 cycles.
//
// Optional feature macro: RENDER_PAUSE_DIM_EN
//   When this macro is defined, game_state 2 (pause) halves every colour
//   channel of the composite. When it is undefined, pause renders exactly
//   like play. Animation is frozen in pause in both builds.
//
// Ports:
//   VGA_clk      pixel clock; all logic is on its rising edge
//   rst          asynchronous, active-high reset
//   display_on   active-video flag, aligned with X and Y
//   frame_start  one-cycle pulse per video frame, during blanking
//   game_state   1 = play, 2 = pause, any other value = black
//   X, Y         current pixel coordinate
//   sprite_x/y   top-left of sprite i in slice [16i+15:16i]
//   sprite_dir   1 = horizontally mirrored
//   sprite_en    layer enable
//   sprite_anim  1 = animation advances
//   rom_row/col  registered ROM address per sprite (8 bits each)
//   rom_frame    registered ROM frame select per sprite
//   rom_data     ROM pixel data, valid ROM_LATENCY cycles after the address
//   RGB          registered output colour
module sprite_layer_renderer #(
  parameter int          N_SPRITES   = 2,
  parameter int          SPRITE_W    = 37,
  parameter int          SPRITE_H    = 42,
  parameter int          FRAMES      = 4,
  parameter int          ANIM_DIV    = 6,
  parameter int          ROM_LATENCY = 1,
  parameter logic [23:0] KEY_COLOUR  = 24'hFF0096,
  parameter logic [23:0] BG_COLOUR   = 24'h2222EE,
  localparam int         FW          = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic                    VGA_clk,
  input  logic                    rst,
  input  logic                    display_on,
  input  logic                    frame_start,
  input  logic [3:0]              game_state,
  input  logic [15:0]             X,
  input  logic [15:0]             Y,
  input  logic [16*N_SPRITES-1:0] sprite_x,
  input  logic [16*N_SPRITES-1:0] sprite_y,
  input  logic [N_SPRITES-1:0]    sprite_dir,
  input  logic [N_SPRITES-1:0]    sprite_en,
  input  logic [N_SPRITES-1:0]    sprite_anim,
  output logic [8*N_SPRITES-1:0]  rom_row,
  output logic [8*N_SPRITES-1:0]  rom_col,
  output logic [FW*N_SPRITES-1:0] rom_frame,
  input  logic [24*N_SPRITES-1:0] rom_data,
  output logic [23:0]             RGB
);

  localparam int             TW     = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  // Hit flags, display_on and game_state must travel through the address
  // register and the ROM read, which is ROM_LATENCY+1 stages in total.
  localparam int             D      = ROM_LATENCY + 1;
  localparam logic [15:0]    W16    = 16'(SPRITE_W);
  localparam logic [15:0]    H16    = 16'(SPRITE_H);
  localparam logic [7:0]     COLMAX = 8'(SPRITE_W - 1);
  localparam logic [FW-1:0]  FMAX   = FW'(FRAMES - 1);
  localparam logic [TW-1:0]  TMAX   = TW'(ANIM_DIV - 1);

  logic [N_SPRITES-1:0][15:0]  dx, dy;
  logic [N_SPRITES-1:0]        hit_now;

  logic [8*N_SPRITES-1:0]      rom_row_d, rom_row_q;
  logic [8*N_SPRITES-1:0]      rom_col_d, rom_col_q;
  logic [FW*N_SPRITES-1:0]     rom_frame_d, rom_frame_q;
  logic [FW*N_SPRITES-1:0]     frame_idx_d, frame_idx_q;
  logic [TW*N_SPRITES-1:0]     tick_d, tick_q;

  logic [D-1:0][N_SPRITES-1:0] hit_pipe_d, hit_pipe_q;
  logic [D-1:0]                de_pipe_d, de_pipe_q;
  logic [D-1:0][3:0]           gs_pipe_d, gs_pipe_q;

  logic [23:0]                 comp;
  logic [23:0]                 rgb_d, rgb_q;

  // Offsets are unsigned with 16-bit wrap, so a pixel left of or above the
  // sprite becomes a huge offset and fails the range test on its own.
  always_comb begin
    dx      = '0;
    dy      = '0;
    hit_now = '0;
    for (int i = 0; i < N_SPRITES; i++) begin
      dx[i]      = X - sprite_x[16*i +: 16];
      dy[i]      = Y - sprite_y[16*i +: 16];
      hit_now[i] = sprite_en[i] && (dx[i] < W16) && (dy[i] < H16);
    end
  end

  // Mirrored column is SPRITE_W-1-dx, so dx = 0 maps onto the last column.
  // On a miss the address is unused, so an 8-bit subtraction is sufficient.
  always_comb begin
    rom_row_d   = '0;
    rom_col_d   = '0;
    rom_frame_d = frame_idx_q;
    for (int i = 0; i < N_SPRITES; i++) begin
      rom_row_d[8*i +: 8] = dy[i][7:0];
      rom_col_d[8*i +: 8] = sprite_dir[i] ? (COLMAX - dx[i][7:0]) : dx[i][7:0];
    end
  end

  // Stage 0 of each shift register takes the live value. The last stage is
  // aligned with rom_data.
  always_comb begin
    hit_pipe_d = '0;
    de_pipe_d  = '0;
    gs_pipe_d  = '0;
    for (int k = 1; k < D; k++) begin
      hit_pipe_d[k] = hit_pipe_q[k-1];
      de_pipe_d[k]  = de_pipe_q[k-1];
      gs_pipe_d[k]  = gs_pipe_q[k-1];
    end
    hit_pipe_d[0] = hit_now;
    de_pipe_d[0]  = display_on;
    gs_pipe_d[0]  = game_state;
  end

  // Walk from the lowest priority up to the highest, so the lowest opaque
  // index is the one that is kept.
  always_comb begin
    comp = BG_COLOUR;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (hit_pipe_q[D-1][i] && (rom_data[24*i +: 24] != KEY_COLOUR))
        comp = rom_data[24*i +: 24];
    end
  end

  always_comb begin
    rgb_d = '0;
    if (de_pipe_q[D-1]) begin
      case (gs_pipe_q[D-1])
        4'd1:    rgb_d = comp;
`ifdef RENDER_PAUSE_DIM_EN
        4'd2:    rgb_d = (comp >> 1) & 24'h7F7F7F;
`else
        4'd2:    rgb_d = comp;
`endif
        default: rgb_d = '0;
      endcase
    end
  end

  // Animation advances only on the frame_start pulse in play. A cleared
  // sprite_anim takes precedence over the tick and rewinds to frame 0.
  always_comb begin
    tick_d      = tick_q;
    frame_idx_d = frame_idx_q;
    if (frame_start && (game_state == 4'd1)) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        if (!sprite_anim[i]) begin
          tick_d[TW*i +: TW]      = '0;
          frame_idx_d[FW*i +: FW] = '0;
        end else if (tick_q[TW*i +: TW] == TMAX) begin
          tick_d[TW*i +: TW]      = '0;
          frame_idx_d[FW*i +: FW] = (frame_idx_q[FW*i +: FW] == FMAX)
                                    ? '0 : frame_idx_q[FW*i +: FW] + FW'(1);
        end else begin
          tick_d[TW*i +: TW]      = tick_q[TW*i +: TW] + TW'(1);
        end
      end
    end
  end

  // All state is cleared asynchronously, so the outputs go black the moment
  // reset asserts.
  always_ff @(posedge VGA_clk or posedge rst) begin
    if (rst) begin
      rom_row_q   <= '0;
      rom_col_q   <= '0;
      rom_frame_q <= '0;
      frame_idx_q <= '0;
      tick_q      <= '0;
      hit_pipe_q  <= '0;
      de_pipe_q   <= '0;
      gs_pipe_q   <= '0;
      rgb_q       <= '0;
    end else begin
      rom_row_q   <= rom_row_d;
      rom_col_q   <= rom_col_d;
      rom_frame_q <= rom_frame_d;
      frame_idx_q <= frame_idx_d;
      tick_q      <= tick_d;
      hit_pipe_q  <= hit_pipe_d;
      de_pipe_q   <= de_pipe_d;
      gs_pipe_q   <= gs_pipe_d;
      rgb_q       <= rgb_d;
    end
  end

  assign rom_row   = rom_row_q;
  assign rom_col   = rom_col_q;
  assign rom_frame = rom_frame_q;
  assign RGB       = rgb_q;

endmodule

// File: tb/tb_sprite_layer_renderer.sv
// tb_sprite_layer_renderer
//
// Bench for sprite_layer_renderer using its default parameters (two
// sprites, 37x42, four frames, ANIM_DIV 6, ROM latency 1).
// Each sprite ROM is modelled as a pipelined lookup with the pattern
// {8'h10 + 32*i + frame, row, col}. A per-sprite override can force a fixed
// colour so that key transparency and priority can be exercised. Pixel
// stimulus pushes its expected colour into a queue. A monitor delays the
// bench's own valid flag by the renderer latency, then pops and compares.
module tb_sprite_layer_renderer;

  localparam int N   = 2;
  localparam int L   = 1;
  localparam int LAT = L + 2;

`ifdef RENDER_PAUSE_DIM_EN
  localparam logic [23:0] PAUSE_BG  = 24'h111177;
  localparam logic [23:0] PAUSE_SPR = 24'h080000;
`else
  localparam logic [23:0] PAUSE_BG  = 24'h2222EE;
  localparam logic [23:0] PAUSE_SPR = 24'h100000;
`endif

  logic             VGA_clk;
  logic             rst;
  logic             display_on;
  logic             frame_start;
  logic [3:0]       game_state;
  logic [15:0]      X, Y;
  logic [16*N-1:0]  sprite_x, sprite_y;
  logic [N-1:0]     sprite_dir, sprite_en, sprite_anim;
  logic [8*N-1:0]   rom_row, rom_col;
  logic [2*N-1:0]   rom_frame;
  logic [24*N-1:0]  rom_data;
  logic [23:0]      RGB;

  typedef struct {
    logic [23:0] rgb;
    int          id;
  } exp_t;

  exp_t         exp_q[$];
  int           next_id;
  int           tests_run;
  int           tests_failed;
  logic         pix_valid;
  logic [LAT-1:0] vpipe;

  logic [23:0]  rom_pipe [N][L];
  logic [N-1:0] force_en;
  logic [23:0]  force_val [N];

  sprite_layer_renderer dut (
    .VGA_clk     (VGA_clk),
    .rst         (rst),
    .display_on  (display_on),
    .frame_start (frame_start),
    .game_state  (game_state),
    .X           (X),
    .Y           (Y),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .sprite_dir  (sprite_dir),
    .sprite_en   (sprite_en),
    .sprite_anim (sprite_anim),
    .rom_row     (rom_row),
    .rom_col     (rom_col),
    .rom_frame   (rom_frame),
    .rom_data    (rom_data),
    .RGB         (RGB)
  );

  initial begin
    VGA_clk = 1'b0;
    forever #5 VGA_clk = ~VGA_clk;
  end

  function automatic logic [23:0] romPattern(input int i, input logic [7:0] r,
                                             input logic [7:0] c, input logic [1:0] f);
    logic [7:0] hi;
    hi = 8'h10 + 8'(i * 32) + {6'b0, f};
    return {hi, r, c};
  endfunction

  // Sprite ROM model with L cycles of read latency
  always @(posedge VGA_clk) begin
    for (int i = 0; i < N; i++) begin
      rom_pipe[i][0] <= romPattern(i, rom_row[8*i +: 8], rom_col[8*i +: 8], rom_frame[2*i +: 2]);
      for (int k = 1; k < L; k++) rom_pipe[i][k] <= rom_pipe[i][k-1];
    end
  end

  always_comb begin
    rom_data = '0;
    for (int i = 0; i < N; i++)
      rom_data[24*i +: 24] = force_en[i] ? force_val[i] : rom_pipe[i][L-1];
  end

  // Output valid is modelled by delaying the bench's own flag by the latency
  always @(posedge VGA_clk or posedge rst) begin
    if (rst) vpipe <= '0;
    else     vpipe <= {vpipe[LAT-2:0], pix_valid};
  end

  always @(negedge VGA_clk) begin
    if (vpipe[LAT-1]) begin
      exp_t e;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL rgb_underflow: got %h, required a queued expectation", RGB);
      end else begin
        e = exp_q.pop_front();
        if (RGB !== e.rgb) begin
          tests_failed++;
          $display("[TB] FAIL rgb#%0d: got %h required %h", e.id, RGB, e.rgb);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y, input logic de,
                               input logic [3:0] gs, input logic chk, input logic [23:0] exp_rgb);
    exp_t e;
    X          = x;
    Y          = y;
    display_on = de;
    game_state = gs;
    pix_valid  = chk;
    if (chk) begin
      e.rgb = exp_rgb;
      e.id  = next_id;
      next_id++;
      exp_q.push_back(e);
    end
    @(posedge VGA_clk);
    #1;
  endtask

  task automatic idle(input int n);
    pix_valid  = 1'b0;
    display_on = 1'b0;
    repeat (n) begin
      @(posedge VGA_clk);
      #1;
    end
  endtask

  task automatic pulseFrame();
    pix_valid   = 1'b0;
    display_on  = 1'b0;
    frame_start = 1'b1;
    @(posedge VGA_clk);
    #1;
    frame_start = 1'b0;
    @(posedge VGA_clk);
    #1;
  endtask

  task automatic setSprite(input int i, input logic [15:0] x, input logic [15:0] y);
    sprite_x[16*i +: 16] = x;
    sprite_y[16*i +: 16] = y;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    next_id      = 0;
    pix_valid    = 1'b0;
    rst          = 1'b1;
    display_on   = 1'b0;
    frame_start  = 1'b0;
    game_state   = 4'd0;
    X            = '0;
    Y            = '0;
    sprite_x     = '0;
    sprite_y     = '0;
    sprite_dir   = '0;
    sprite_en    = '0;
    sprite_anim  = '0;
    force_en     = '0;
    force_val[0] = '0;
    force_val[1] = '0;

    // Reset state
    repeat (3) @(posedge VGA_clk);
    #2;
    checkOutput("reset_rgb", 32'(RGB), 32'h0);
    checkOutput("reset_row", 32'(rom_row), 32'h0);
    checkOutput("reset_col", 32'(rom_col), 32'h0);
    checkOutput("reset_frame", 32'(rom_frame), 32'h0);
    @(posedge VGA_clk);
    #1;
    rst = 1'b0;

    // Background, then blanking
    for (int i = 0; i < 6; i++) applyStimulus(16'(i), 16'd5, 1'b1, 4'd1, 1'b1, 24'h2222EE);
    for (int i = 0; i < 3; i++) applyStimulus(16'(i), 16'd5, 1'b0, 4'd1, 1'b1, 24'h000000);

    // Mirroring and edges of sprite 0 at (100,50)
    setSprite(0, 16'd100, 16'd50);
    setSprite(1, 16'd110, 16'd50);
    sprite_en  = 2'b01;
    sprite_dir = 2'b00;
    applyStimulus(16'd100, 16'd50, 1'b1, 4'd1, 1'b1, 24'h100000);
    checkOutput("col_dir0", 32'(rom_col[7:0]), 32'd0);
    sprite_dir = 2'b01;
    applyStimulus(16'd100, 16'd50, 1'b1, 4'd1, 1'b1, 24'h100024);
    checkOutput("col_dir1", 32'(rom_col[7:0]), 32'd36);
    sprite_dir = 2'b00;
    applyStimulus(16'd99,  16'd50, 1'b1, 4'd1, 1'b1, 24'h2222EE);
    applyStimulus(16'd137, 16'd50, 1'b1, 4'd1, 1'b1, 24'h2222EE);
    applyStimulus(16'd136, 16'd50, 1'b1, 4'd1, 1'b1, 24'h100024);
    applyStimulus(16'd100, 16'd91, 1'b1, 4'd1, 1'b1, 24'h102900);
    checkOutput("row_last", 32'(rom_row[7:0]), 32'd41);
    applyStimulus(16'd100, 16'd92, 1'b1, 4'd1, 1'b1, 24'h2222EE);
    applyStimulus(16'd100, 16'd49, 1'b1, 4'd1, 1'b1, 24'h2222EE);

    // Overlap with ROM patterns: sprite 0 wins, sprite 1 shows beyond it
    sprite_en = 2'b11;
    applyStimulus(16'd110, 16'd60, 1'b1, 4'd1, 1'b1, 24'h100A0A);
    applyStimulus(16'd140, 16'd60, 1'b1, 4'd1, 1'b1, 24'h300A1E);
    idle(LAT + 1);

    // Key transparency and priority with forced ROM colours
    setSprite(1, 16'd100, 16'd50);
    force_en     = 2'b11;
    force_val[0] = 24'hFF0096;
    force_val[1] = 24'h00FF00;
    applyStimulus(16'd100, 16'd50, 1'b1, 4'd1, 1'b1, 24'h00FF00);
    applyStimulus(16'd120, 16'd70, 1'b1, 4'd1, 1'b1, 24'h00FF00);
    idle(LAT + 1);
    force_val[0] = 24'hFF0000;
    applyStimulus(16'd100, 16'd50, 1'b1, 4'd1, 1'b1, 24'hFF0000);
    idle(LAT + 1);
    force_val[1] = 24'hFF0096;
    force_val[0] = 24'hFF0096;
    applyStimulus(16'd100, 16'd50, 1'b1, 4'd1, 1'b1, 24'h2222EE);
    idle(LAT + 1);
    force_en  = 2'b00;
    sprite_en = 2'b01;

    // Animation: frame steps every 6 pulses and wraps after 4 frames
    game_state  = 4'd1;
    sprite_anim = 2'b01;
    for (int k = 1; k <= 30; k++) begin
      pulseFrame();
      checkOutput($sformatf("anim_p%0d", k), 32'(rom_frame[1:0]), 32'((k / 6) % 4));
    end
    checkOutput("anim_s1", 32'(rom_frame[3:2]), 32'd0);
    game_state = 4'd2;
    for (int k = 1; k <= 10; k++) pulseFrame();
    checkOutput("anim_pause", 32'(rom_frame[1:0]), 32'd1);
    game_state  = 4'd1;
    sprite_anim = 2'b00;
    pulseFrame();
    checkOutput("anim_clear", 32'(rom_frame[1:0]), 32'd0);

    // Pause rendering and game_state switching in pixel order
    applyStimulus(16'd0,   16'd0,  1'b1, 4'd2, 1'b1, PAUSE_BG);
    applyStimulus(16'd100, 16'd50, 1'b1, 4'd2, 1'b1, PAUSE_SPR);
    applyStimulus(16'd0,   16'd0,  1'b1, 4'd4, 1'b1, 24'h000000);
    applyStimulus(16'd0,   16'd0,  1'b1, 4'd0, 1'b1, 24'h000000);
    applyStimulus(16'd0,   16'd0,  1'b1, 4'd1, 1'b1, 24'h2222EE);
    applyStimulus(16'd0,   16'd0,  1'b0, 4'd2, 1'b1, 24'h000000);
    applyStimulus(16'd100, 16'd50, 1'b1, 4'd1, 1'b1, 24'h100000);
    idle(LAT + 1);

    // Reset mid-frame while a sprite pixel is being output
    sprite_anim = 2'b01;
    for (int k = 0; k < 6; k++) pulseFrame();
    checkOutput("pre_reset_frame", 32'(rom_frame[1:0]), 32'd1);
    for (int k = 0; k < 4; k++) applyStimulus(16'd100, 16'd50, 1'b1, 4'd1, 1'b1, 24'h110000);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_rgb", 32'(RGB), 32'h0);
    checkOutput("rst_frame", 32'(rom_frame), 32'h0);
    exp_q.delete();
    pix_valid = 1'b0;
    @(posedge VGA_clk);
    @(posedge VGA_clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c <= LAT; c++) begin
      @(negedge VGA_clk);
      checkOutput($sformatf("refill_c%0d", c), 32'(RGB), (c == LAT) ? 32'h100000 : 32'h0);
    end

    idle(LAT + 2);
    checkOutput("queue_left", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
